// File: rtl/gray_counter.sv
// ---------------------------------------------------------------------------
// gray_counter
//
// Registered up/down Gray-code counter. An internal binary count is kept,
// and its Gray encoding is produced from the *next* binary value so that
// bin and gray are captured by the same flop stage. The Gray output never
// lags bin and never glitches, because it comes straight from a register.
//
// Typical uses are async-FIFO pointers, position encoders, and any stage
// that feeds a downstream Gray-to-binary decoder.
//
// Parameters:
//   WIDTH     counter and code width in bits (2..32)
//
// Ports:
//   clk       system clock; all state updates on the rising edge
//   rst       synchronous reset, active-high; clears bin, gray and wrap
//   en        count enable; one step per clock while high
//   up_dn     direction when counting: 1 = increment, 0 = decrement
//   load      synchronous load strobe; wins over en
//   load_bin  binary value captured when load is high
//   bin       registered binary count
//   gray      registered Gray code of bin (bin ^ (bin >> 1))
//   wrap      one-cycle pulse on the edge where the count rolls over
//
// Edge priority: rst > load > en > hold.
// ---------------------------------------------------------------------------
module gray_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap
);

  // Operation chosen for the coming edge, ignoring reset. Reset is handled
  // in the register process so it overrides everything unconditionally.
  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_UP   = 2'd2,
    OP_DOWN = 2'd3
  } op_t;

  localparam logic [WIDTH-1:0] ZERO     = '0;
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  op_t              op;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_next;
  logic             wrap_next;

  // Decode the control inputs into a single operation. Load outranks the
  // enable, and up_dn only matters once we know we are really counting.
  always_comb begin
    op = OP_HOLD;
    if (load) begin
      op = OP_LOAD;
    end else if (en) begin
      if (up_dn) begin
        op = OP_UP;
      end else begin
        op = OP_DOWN;
      end
    end
  end

  // Next binary value and rollover flag. Arithmetic is plain WIDTH-bit
  // unsigned, so the carry or borrow falls off the top; the only trace it
  // leaves is the wrap pulse, detected from the value we are leaving.
  always_comb begin
    bin_next  = bin;
    wrap_next = 1'b0;
    unique case (op)
      OP_LOAD: begin
        bin_next = load_bin;
      end
      OP_UP: begin
        bin_next  = bin + ONE;
        wrap_next = (bin == ALL_ONES);
      end
      OP_DOWN: begin
        bin_next  = bin - ONE;
        wrap_next = (bin == ZERO);
      end
      default: begin
        bin_next = bin;
      end
    endcase
  end

  // Gray encoding of the value about to be registered. Encoding the next
  // state (rather than the current output) keeps gray aligned with bin on
  // the same edge with no extra cycle of latency.
  always_comb begin
    gray_next = bin_next ^ (bin_next >> 1);
  end

  // Single register stage for the count, its Gray code and the wrap pulse.
  // Reset is synchronous and beats load and enable, so a reset arriving
  // mid-count leaves no residual step behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin  <= ZERO;
      gray <= ZERO;
      wrap <= 1'b0;
    end else begin
      bin  <= bin_next;
      gray <= gray_next;
      wrap <= wrap_next;
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// ---------------------------------------------------------------------------
// tb_gray_counter
//
// Directed and randomized checks for gray_counter at WIDTH = 4. Each
// scenario lives in its own task and compares the registered outputs one
// time unit after the rising edge that produced them.
// ---------------------------------------------------------------------------
module tb_gray_counter;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] gray;
  logic             wrap;

  int checks;
  int errors;

  gray_counter #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_bin (load_bin),
    .bin      (bin),
    .gray     (gray),
    .wrap     (wrap)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare all three outputs against hand-computed values.
  task automatic expect_state(input string name, input logic [3:0] eb,
                              input logic [3:0] eg, input logic ew);
    checks++;
    if (bin !== eb) begin
      errors++;
      $display("[TB] FAIL %s bin: got %b expected %b", name, bin, eb);
    end
    checks++;
    if (gray !== eg) begin
      errors++;
      $display("[TB] FAIL %s gray: got %b expected %b", name, gray, eg);
    end
    checks++;
    if (wrap !== ew) begin
      errors++;
      $display("[TB] FAIL %s wrap: got %b expected %b", name, wrap, ew);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; up_dn = 1'b1; load_bin = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; up_dn = 1'b1; load = 1'b1; load_bin = 4'b1011;
    step();
    expect_state("reset", 4'b0000, 4'b0000, 1'b0);
    rst = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  // Full up cycle: the Gray sequence is written out by hand.
  task automatic test_count_up();
    logic [3:0] exp_gray [16];
    logic [3:0] prev;
    exp_gray = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                 4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    do_reset();
    prev = 4'b0000;
    en = 1'b1; up_dn = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      expect_state($sformatf("count_up[%0d]", k), 4'(k % 16),
                   exp_gray[k % 16], (k == 16));
      checks++;
      if ($countones(gray ^ prev) != 1) begin
        errors++;
        $display("[TB] FAIL count_up_hamming[%0d]: got %b after %b expected one bit change",
                 k, gray, prev);
      end
      prev = exp_gray[k % 16];
    end
    step();
    expect_state("count_up_after_wrap", 4'b0001, 4'b0001, 1'b0);
    en = 1'b0;
  endtask

  task automatic test_down_wrap();
    do_reset();
    en = 1'b1; up_dn = 1'b0;
    step();
    expect_state("down_wrap", 4'b1111, 4'b1000, 1'b1);
    step();
    expect_state("down_after_wrap", 4'b1110, 4'b1001, 1'b0);
    en = 1'b0;
  endtask

  task automatic test_load_priority();
    do_reset();
    load = 1'b1; load_bin = 4'b1010; en = 1'b1; up_dn = 1'b1;
    step();
    expect_state("load_wins", 4'b1010, 4'b1111, 1'b0);
    load = 1'b0;
    step();
    expect_state("after_load", 4'b1011, 4'b1110, 1'b0);
    load = 1'b1; load_bin = 4'b1111; en = 1'b0;
    step();
    expect_state("load_ones", 4'b1111, 4'b1000, 1'b0);
    load_bin = 4'b0011; en = 1'b1; up_dn = 1'b1;
    step();
    expect_state("load_at_ones_no_wrap", 4'b0011, 4'b0010, 1'b0);
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_reset_midcount();
    do_reset();
    en = 1'b1; up_dn = 1'b1;
    repeat (5) step();
    expect_state("midcount_pre", 4'b0101, 4'b0111, 1'b0);
    rst = 1'b1;
    step();
    expect_state("midcount_reset", 4'b0000, 4'b0000, 1'b0);
    rst = 1'b0;
    step();
    expect_state("midcount_resume", 4'b0001, 4'b0001, 1'b0);
    en = 1'b0;
  endtask

  task automatic test_hold_and_reversal();
    load = 1'b1; load_bin = 4'b0111; en = 1'b0;
    step();
    load = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      expect_state($sformatf("hold[%0d]", k), 4'b0111, 4'b0100, 1'b0);
    end
    en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      up_dn = (k % 2 == 0);
      step();
      if (k % 2 == 0)
        expect_state($sformatf("reverse[%0d]", k), 4'b1000, 4'b1100, 1'b0);
      else
        expect_state($sformatf("reverse[%0d]", k), 4'b0111, 4'b0100, 1'b0);
    end
    en = 1'b0;
  endtask

  // Random stimulus against a behavioural reference. Wrap is derived from
  // where the count lands rather than where it started.
  task automatic test_random();
    logic [3:0] m_bin, m_gray, prev_gray, m_bin_prev;
    logic       m_wrap, stepped;
    logic [31:0] r;
    do_reset();
    m_bin = 4'd0; m_gray = 4'd0; m_wrap = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      r = $urandom;
      rst      = (r[5:0] == 6'd0);
      load     = (r[8:6] == 3'd0);
      en       = (r[10:9] != 2'd0);
      up_dn    = r[11];
      load_bin = r[15:12];
      prev_gray  = m_gray;
      m_bin_prev = m_bin;
      stepped    = 1'b0;
      m_wrap     = 1'b0;
      if (rst) begin
        m_bin = 4'd0;
      end else if (load) begin
        m_bin = load_bin;
      end else if (en) begin
        stepped = 1'b1;
        if (up_dn) begin
          m_bin  = m_bin_prev + 4'd1;
          m_wrap = (m_bin == 4'd0);
        end else begin
          m_bin  = m_bin_prev - 4'd1;
          m_wrap = (m_bin == 4'hF);
        end
      end
      m_gray = {m_bin[3], m_bin[3] ^ m_bin[2], m_bin[2] ^ m_bin[1], m_bin[1] ^ m_bin[0]};
      step();
      checks++;
      if (bin !== m_bin || gray !== m_gray || wrap !== m_wrap) begin
        errors++;
        $display("[TB] FAIL random[%0d]: got bin=%b gray=%b wrap=%b expected bin=%b gray=%b wrap=%b",
                 c, bin, gray, wrap, m_bin, m_gray, m_wrap);
      end
      checks++;
      if (gray !== (bin ^ (bin >> 1))) begin
        errors++;
        $display("[TB] FAIL random_encode[%0d]: got gray=%b for bin=%b", c, gray, bin);
      end
      if (stepped) begin
        checks++;
        if ($countones(gray ^ prev_gray) != 1) begin
          errors++;
          $display("[TB] FAIL random_hamming[%0d]: got %b after %b expected one bit change",
                   c, gray, prev_gray);
        end
      end
    end
    rst = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_bin = '0;
    test_reset();
    test_count_up();
    test_down_wrap();
    test_load_priority();
    test_reset_midcount();
    test_hold_and_reversal();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
